apb_master_bridge: RTL and testbench
====================================

Name: apb_master_bridge

Overview:
- Sits directly downstream of the RV32I core's data-bus port (busWe/busAddr/busWData/busRData).
- Converts each CPU load/store into one APB3 transfer: SETUP phase, then ACCESS phase, with wait states.
- Decodes the address to one of NUM_SLAVES peripheral selects and muxes the selected slave's PRDATA back to the core.
- Returns a one-cycle ready strobe that the core uses to stall its PC.

Parameters:
- NUM_SLAVES, 5, number of PSEL/PRDATA/PREADY slave ports (RAM, GPO, GPI, GPIO, UART).
- BASE_ADDR, 32'h1000_0000, start of the peripheral region; each slave owns one 4 KiB window at BASE_ADDR + i*0x1000.
- TIMEOUT_CYCLES, 255, maximum ACCESS-phase cycles before the transfer is aborted with an error.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- transfer  in  1  CPU request strobe, sampled only when the bridge can accept a request.
- write  in  1  1 = store, 0 = load (from busWe).
- addr  in  32  CPU byte address (from busAddr).
- wdata  in  32  store data (from busWData).
- rdata  out  32  load data to the CPU (to busRData).
- ready  out  1  one-cycle completion strobe.
- err  out  1  high together with ready when the access was unmapped or timed out.
- PADDR  out  32  latched address.
- PWDATA  out  32  latched write data.
- PWRITE  out  1  latched direction.
- PENABLE  out  1  ACCESS-phase indicator.
- PSEL  out  NUM_SLAVES  one-hot slave select.
- PRDATA  in  NUM_SLAVES*32  slave read data, slave i in bits [32i+31:32i].
- PREADY  in  NUM_SLAVES  per-slave ready.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high, applied on the rising edge.
- Reset values: state=IDLE; PADDR, PWDATA, rdata = 0; PWRITE, PENABLE, ready, err = 0; PSEL = 0; timeout counter = 0.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - On transfer=1, latch addr, wdata and write into the P* registers and go to SETUP.
  - Otherwise stay in IDLE.
- SETUP (exactly one cycle):
  - PSEL[dec]=1, PENABLE=0.
  - Go to ACCESS and clear the timeout counter.
- ACCESS:
  - PSEL[dec]=1, PENABLE=1; PADDR, PWDATA and PWRITE are held stable.
  - If PREADY[dec]=1: ready=1 this cycle (combinational); rdata = PRDATA[dec] when PWRITE=0, else 0.
  - After completion, with transfer=1 in the same cycle: latch the new request and go to SETUP (back-to-back, with PENABLE dropping).
  - After completion, with transfer=0: go to IDLE, with PSEL and PENABLE low next cycle.
  - If PREADY[dec]=0: increment the counter. When the counter reaches TIMEOUT_CYCLES-1 with no PREADY, assert ready=1 and err=1, drive rdata=0, and go to IDLE.
- Address decode:
  - dec = (PADDR - BASE_ADDR) >> 12, valid when 0 <= dec < NUM_SLAVES.
  - The decode is taken from the latched PADDR, never from the live addr.
- Unmapped address:
  - SETUP still occurs with PSEL all-zero.
  - In the first ACCESS cycle: ready=1, err=1, rdata=0, no slave is touched.
- transfer is ignored while in SETUP, and in ACCESS when no completion occurs in that cycle; the core holds its bus signals stable until ready.
- Minimum latency: transfer at cycle N leads to SETUP at N+1, ACCESS at N+2, and ready at N+2 when the slave responds with zero wait states.
- ready and err are never high outside ACCESS.
- Reset asserted mid-transfer: all outputs go to reset values on the next edge; no ready is produced for the aborted transfer.

Decomposition:
- Shared package apb_pkg:
  - State enum apb_state_e {IDLE, SETUP, ACCESS}.
  - BASE_ADDR and the per-slave window constants (SLV_RAM=0, SLV_GPO=1, SLV_GPI=2, SLV_GPIO=3, SLV_UART=4).
  - Window size 0x1000.
- One sub-module, apb_addr_decoder:
  - Combinational; PADDR in, PSEL one-hot enable vector, index and valid out.
  - The read mux and PREADY mux are driven from its index.

Test Plan:
- Write to RAM, zero wait: transfer=1, write=1, addr=0x1000_0004, wdata=0xDEAD_BEEF. SETUP next cycle with PSEL=5'b00001, PENABLE=0. Then ACCESS with PENABLE=1, PADDR=0x1000_0004, PWDATA=0xDEAD_BEEF. PREADY[0]=1 gives ready=1, err=0, two cycles after transfer.
- Read from GPI, 3 wait states: addr=0x1000_2000, PRDATA[2]=0x0000_00A5, PREADY[2] low for 3 ACCESS cycles. ACCESS lasts 4 cycles, PADDR is stable throughout, and ready=1 with rdata=0x0000_00A5 exactly once.
- Back-to-back: a second request (read UART 0x1000_4008) is presented in the completion cycle of a GPO write. The next cycle is SETUP with PSEL=5'b10000 and PENABLE=0, with no IDLE cycle in between.
- Unmapped: addr=0x2000_0000. PSEL stays 0 in all cycles; ready=1, err=1, rdata=0 two cycles after transfer.
- Timeout: PREADY[3] held at 0 on a GPIO access. ready=1 and err=1 after 255 ACCESS cycles, then IDLE, with PSEL and PENABLE at 0.
- Reset mid-ACCESS: rst=1 during a wait state. Next edge gives PSEL=0, PENABLE=0, ready=0, state=IDLE. A new transfer after reset completes normally.

Source files
------------

// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the APB master bridge slice: bridge state encoding,
// the peripheral region base address, window size and the slot index of each
// peripheral inside the region.
// -----------------------------------------------------------------------------
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_e;

  // Peripheral region: one 4 KiB window per slave, laid out back to back.
  localparam logic [31:0] BASE_ADDR    = 32'h1000_0000;
  localparam logic [31:0] WINDOW_SIZE  = 32'h0000_1000;
  localparam int          WINDOW_SHIFT = 12;

  // Slot index of each peripheral (window i starts at BASE_ADDR + i*WINDOW_SIZE).
  localparam int SLV_RAM  = 0;
  localparam int SLV_GPO  = 1;
  localparam int SLV_GPI  = 2;
  localparam int SLV_GPIO = 3;
  localparam int SLV_UART = 4;

endpackage

// File: rtl/apb_master_bridge_if.sv
// -----------------------------------------------------------------------------
// apb_master_bridge_if
// APB3 bus between the bridge (master modport) and the peripheral slaves
// (slave modport).
//   PADDR/PWDATA/PWRITE : latched transfer address, write data, direction
//   PENABLE             : ACCESS-phase indicator
//   PSEL                : one-hot slave select
//   PRDATA              : slave read data, slave i in bits [32i+31:32i]
//   PREADY              : per-slave ready
// -----------------------------------------------------------------------------
interface apb_master_bridge_if #(
  parameter int NUM_SLAVES = 5
);

  logic [31:0]              PADDR;
  logic [31:0]              PWDATA;
  logic                     PWRITE;
  logic                     PENABLE;
  logic [NUM_SLAVES-1:0]    PSEL;
  logic [NUM_SLAVES*32-1:0] PRDATA;
  logic [NUM_SLAVES-1:0]    PREADY;

  modport master (
    output PADDR, PWDATA, PWRITE, PENABLE, PSEL,
    input  PRDATA, PREADY
  );

  modport slave (
    input  PADDR, PWDATA, PWRITE, PENABLE, PSEL,
    output PRDATA, PREADY
  );

endinterface

// File: rtl/apb_addr_decoder.sv
// -----------------------------------------------------------------------------
// apb_addr_decoder
// Combinational decode of a byte address into a peripheral slot.
//   paddr : latched APB address
//   sel   : one-hot select, all-zero when the address is unmapped
//   idx   : slot index (meaningful only when valid)
//   valid : address falls inside one of the NUM_SLAVES windows
// -----------------------------------------------------------------------------
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int          NUM_SLAVES = 5,
  parameter logic [31:0] BASE       = 32'h1000_0000,
  parameter int          IDX_W      = 3
) (
  input  logic [31:0]           paddr,
  output logic [NUM_SLAVES-1:0] sel,
  output logic [IDX_W-1:0]      idx,
  output logic                  valid
);

  logic [31:0] offset;

  // NOTE: every output of a combinational block gets a default at the top so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    // Addresses below BASE wrap to a huge offset and so fail the range test.
    offset = paddr - BASE;
    valid  = offset < (32'(NUM_SLAVES) << WINDOW_SHIFT);
    idx    = offset[WINDOW_SHIFT +: IDX_W];
    sel    = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (valid && idx == IDX_W'(i)) sel[i] = 1'b1;
    end
  end

endmodule

// File: rtl/apb_master_bridge.sv
// -----------------------------------------------------------------------------
// apb_master_bridge
// Turns each CPU data-bus load/store into one APB3 transfer (SETUP then
// ACCESS with wait states) and returns a one-cycle completion strobe.
//   clk, rst          : clock, synchronous active-high reset
//   transfer          : request strobe, sampled in IDLE or in a completion cycle
//   write/addr/wdata  : request direction, byte address, store data
//   rdata             : load data, valid while ready is high
//   ready             : one-cycle completion strobe (stalls the core's PC)
//   err               : with ready, access was unmapped or timed out
//   apb               : APB3 master port
// -----------------------------------------------------------------------------
module apb_master_bridge #(
  parameter int          NUM_SLAVES     = 5,
  parameter logic [31:0] BASE_ADDR      = apb_pkg::BASE_ADDR,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                transfer,
  input  logic                write,
  input  logic [31:0]         addr,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata,
  output logic                ready,
  output logic                err,
  apb_master_bridge_if.master apb
);

  import apb_pkg::*;

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  apb_state_e              state;
  logic [CNT_W-1:0]        cnt;
  logic [NUM_SLAVES-1:0]   dec_sel;
  logic [IDX_W-1:0]        dec_idx;
  logic                    dec_valid;
  logic                    slv_ready;
  logic [31:0]             slv_rdata;
  logic                    in_access;
  logic                    timeout_hit;

  // Decode always works on the latched PADDR so the live CPU address may move.
  apb_addr_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .BASE       (BASE_ADDR),
    .IDX_W      (IDX_W)
  ) u_dec (
    .paddr (apb.PADDR),
    .sel   (dec_sel),
    .idx   (dec_idx),
    .valid (dec_valid)
  );

  // Read-data and ready mux, steered by the decoded slot index.
  always_comb begin
    slv_ready = 1'b0;
    slv_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (dec_valid && dec_idx == IDX_W'(i)) begin
        slv_ready = apb.PREADY[i];
        slv_rdata = apb.PRDATA[i*32 +: 32];
      end
    end
  end

  assign in_access   = (state == ACCESS);
  assign timeout_hit = dec_valid && !slv_ready && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Unmapped accesses complete with an error in their first ACCESS cycle.
  assign ready = in_access && (!dec_valid || slv_ready || timeout_hit);
  assign err   = in_access && (!dec_valid || timeout_hit);
  assign rdata = (in_access && slv_ready && !apb.PWRITE) ? slv_rdata : '0;

  // Select stays asserted for the whole SETUP+ACCESS window of a transfer.
  assign apb.PSEL = (state != IDLE) ? dec_sel : '0;

  // NOTE: all state in a clocked block uses non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      apb.PADDR   <= '0;
      apb.PWDATA  <= '0;
      apb.PWRITE  <= 1'b0;
      apb.PENABLE <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (transfer) begin
            apb.PADDR  <= addr;
            apb.PWDATA <= wdata;
            apb.PWRITE <= write;
            state      <= SETUP;
          end
        end
        SETUP: begin
          apb.PENABLE <= 1'b1;
          cnt         <= '0;
          state       <= ACCESS;
        end
        ACCESS: begin
          if (ready) begin
            apb.PENABLE <= 1'b0;
            // A request presented in the completion cycle chains straight
            // into the next SETUP without an IDLE bubble.
            if (transfer) begin
              apb.PADDR  <= addr;
              apb.PWDATA <= wdata;
              apb.PWRITE <= write;
              state      <= SETUP;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// -----------------------------------------------------------------------------
// tb_apb_master_bridge
// Transaction-level model: each request is described by its address, direction,
// data and slave wait count; the expected cycle-by-cycle bus picture is derived
// from the protocol timeline (request, one SETUP cycle, ACCESS until response,
// unmapped completion or timeout). One negedge process compares the DUT to it.
// -----------------------------------------------------------------------------
module tb_apb_master_bridge;
  import apb_pkg::*;

  localparam int          NS   = 5;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int          TMO  = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        transfer;
  logic        write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;

  apb_master_bridge_if #(.NUM_SLAVES(NS)) apb_if ();

  apb_master_bridge #(
    .NUM_SLAVES     (NS),
    .BASE_ADDR      (BASE),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .transfer (transfer),
    .write    (write),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .ready    (ready),
    .err      (err),
    .apb      (apb_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    int          waits;
    bit          chain;
    int          gap;
    bit          fixed_rd;
    logic [31:0] rd_val;
  } txn_t;

  typedef struct {
    bit          valid;
    bit          bus;
    logic [NS-1:0] psel;
    logic        penable;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        pwrite;
    logic        ready;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t ex;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ready_cnt = 0;
  int last_ready_cyc = 0;
  logic [31:0] last_rdata = '0;
  logic        last_err = 1'b0;
  int req_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at time %0t", name, act, req, $time);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    cyc++;
    if (ex.valid) begin
      check("psel",    32'(apb_if.PSEL),    32'(ex.psel));
      check("penable", 32'(apb_if.PENABLE), 32'(ex.penable));
      check("ready",   32'(ready),          32'(ex.ready));
      check("err",     32'(err),            32'(ex.err));
      check("rdata",   rdata,               ex.rdata);
      if (ex.bus) begin
        check("paddr",  apb_if.PADDR,        ex.paddr);
        check("pwdata", apb_if.PWDATA,       ex.pwdata);
        check("pwrite", 32'(apb_if.PWRITE),  32'(ex.pwrite));
      end
    end
    if (ready === 1'b1) begin
      ready_cnt++;
      last_rdata     = rdata;
      last_err       = err;
      last_ready_cyc = cyc;
    end
  end

  // ---------------- behavioural model helpers ----------------
  // Slot of an address, or -1 when it lies outside the peripheral region.
  function automatic int model_dec(input logic [31:0] a);
    longint unsigned ua = 64'(a);
    longint unsigned lo = 64'(BASE);
    if (ua >= lo && ua < lo + NS * 4096) return int'((ua - lo) / 4096);
    return -1;
  endfunction

  // Number of ACCESS cycles a transfer occupies.
  function automatic int model_len(input int d, input int waits);
    if (d < 0) return 1;
    if (waits < TMO) return waits + 1;
    return TMO;
  endfunction

  function automatic txn_t mk(input logic [31:0] a, input logic w, input logic [31:0] wd,
                              input int waits, input bit chain, input int gap,
                              input bit fixed_rd, input logic [31:0] rd_val);
    txn_t t;
    t.addr = a; t.write = w; t.wdata = wd; t.waits = waits; t.chain = chain;
    t.gap = gap; t.fixed_rd = fixed_rd; t.rd_val = rd_val;
    return t;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic junk();
    transfer = 1'($urandom_range(0, 1));
    write    = 1'($urandom_range(0, 1));
    addr     = $urandom;
    wdata    = $urandom;
    for (int i = 0; i < NS; i++) apb_if.PRDATA[i*32 +: 32] = $urandom;
    apb_if.PREADY = NS'($urandom);
  endtask

  task automatic set_exp(input bit bus, input logic [NS-1:0] psel, input logic pen,
                         input logic [31:0] pa, input logic [31:0] pw, input logic pwr,
                         input logic rdy, input logic er, input logic [31:0] rd);
    ex.valid = 1'b1; ex.bus = bus; ex.psel = psel; ex.penable = pen;
    ex.paddr = pa; ex.pwdata = pw; ex.pwrite = pwr;
    ex.ready = rdy; ex.err = er; ex.rdata = rd;
  endtask

  task automatic set_idle_exp();
    set_exp(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic present(input txn_t t);
    transfer = 1'b1;
    write    = t.write;
    addr     = t.addr;
    wdata    = t.wdata;
  endtask

  // Runs one transfer. If presented=0 the request cycle is driven here from
  // IDLE; otherwise it was presented in the previous completion cycle.
  task automatic run_txn(input txn_t t, input bit presented, input bit has_next, input txn_t nx);
    int d;
    int len;
    bit tmo;
    bit last;
    logic [NS-1:0] sel;
    logic [31:0] rd;
    d   = model_dec(t.addr);
    len = model_len(d, t.waits);
    tmo = (d >= 0) && (t.waits >= TMO);
    sel = '0;
    if (d >= 0) sel[d] = 1'b1;
    if (!presented) begin
      junk();
      present(t);
      set_idle_exp();
      req_cyc = cyc + 1;
      step();
    end
    // SETUP
    junk();
    set_exp(1'b1, sel, 1'b0, t.addr, t.wdata, t.write, 1'b0, 1'b0, '0);
    step();
    // ACCESS
    for (int k = 0; k < len; k++) begin
      last = (k == len - 1);
      junk();
      if (d >= 0) begin
        apb_if.PREADY[d] = (k == t.waits);
        if (last && t.fixed_rd) apb_if.PRDATA[d*32 +: 32] = t.rd_val;
      end
      rd = '0;
      if (last && d >= 0 && !tmo && !t.write) rd = apb_if.PRDATA[d*32 +: 32];
      set_exp(1'b1, sel, 1'b1, t.addr, t.wdata, t.write, last, last && (d < 0 || tmo), rd);
      if (last) begin
        if (has_next && t.chain) present(nx);
        else transfer = 1'b0;
      end
      step();
    end
    if (!(has_next && t.chain)) begin
      for (int g = 0; g < t.gap; g++) begin
        junk();
        transfer = 1'b0;
        set_idle_exp();
        step();
      end
    end
  endtask

  txn_t none;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not end within the time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t q[$];
    txn_t t;
    int   rc0;
    int   gpo_rdy;
    int   r;
    int   slot;

    none = mk('0, 1'b0, '0, 0, 1'b0, 0, 1'b0, '0);
    ex.valid = 1'b0;
    rst = 1'b1; transfer = 1'b0; write = 1'b0; addr = '0; wdata = '0;
    apb_if.PRDATA = '0; apb_if.PREADY = '0;
    repeat (2) step();

    // Reset values, with request inputs active during reset.
    junk();
    transfer = 1'b1;
    set_exp(1'b1, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
    step();
    rst = 1'b0;

    // Pin the model against hand-derived values.
    check("pin_dec_ram",   32'(model_dec(32'h1000_0004)), 32'(SLV_RAM));
    check("pin_dec_gpi",   32'(model_dec(32'h1000_2000)), 32'(SLV_GPI));
    check("pin_dec_uart",  32'(model_dec(32'h1000_4008)), 32'(SLV_UART));
    check("pin_dec_unmap", 32'(model_dec(32'h2000_0000)), 32'hFFFF_FFFF);
    check("pin_dec_top",   32'(model_dec(32'h1000_5000)), 32'hFFFF_FFFF);
    check("pin_len_3w",    32'(model_len(2, 3)), 32'd4);
    check("pin_len_tmo",   32'(model_len(3, 1000)), 32'd255);

    // RAM write, zero wait.
    rc0 = ready_cnt;
    run_txn(mk(32'h1000_0004, 1'b1, 32'hDEAD_BEEF, 0, 1'b0, 1, 1'b0, '0), 1'b0, 1'b0, none);
    check("ram_wr_once",    32'(ready_cnt - rc0), 32'd1);
    check("ram_wr_latency", 32'(last_ready_cyc - req_cyc), 32'd2);
    check("ram_wr_err",     32'(last_err), 32'd0);

    // GPI read, three wait states.
    rc0 = ready_cnt;
    run_txn(mk(32'h1000_2000, 1'b0, 32'h0, 3, 1'b0, 1, 1'b1, 32'h0000_00A5), 1'b0, 1'b0, none);
    check("gpi_rd_once",    32'(ready_cnt - rc0), 32'd1);
    check("gpi_rd_data",    last_rdata, 32'h0000_00A5);
    check("gpi_rd_latency", 32'(last_ready_cyc - req_cyc), 32'd5);

    // Back-to-back: GPO write, UART read presented in its completion cycle.
    t = mk(32'h1000_4008, 1'b0, 32'h0, 1, 1'b0, 2, 1'b1, 32'h5A5A_0001);
    run_txn(mk(32'h1000_1000, 1'b1, 32'h0000_00FF, 0, 1'b1, 0, 1'b0, '0), 1'b0, 1'b1, t);
    gpo_rdy = last_ready_cyc;
    run_txn(t, 1'b1, 1'b0, none);
    check("b2b_spacing", 32'(last_ready_cyc - gpo_rdy), 32'd3);
    check("b2b_rdata",   last_rdata, 32'h5A5A_0001);

    // Unmapped.
    run_txn(mk(32'h2000_0000, 1'b0, 32'h0, 0, 1'b0, 1, 1'b0, '0), 1'b0, 1'b0, none);
    check("unmap_latency", 32'(last_ready_cyc - req_cyc), 32'd2);
    check("unmap_err",     32'(last_err), 32'd1);
    check("unmap_rdata",   last_rdata, 32'h0);

    // Timeout on GPIO.
    run_txn(mk(32'h1000_3010, 1'b0, 32'h0, 1000, 1'b0, 2, 1'b0, '0), 1'b0, 1'b0, none);
    check("tmo_latency", 32'(last_ready_cyc - req_cyc), 32'd256);
    check("tmo_err",     32'(last_err), 32'd1);

    // Slave answers on the very last allowed ACCESS cycle: no error.
    run_txn(mk(32'h1000_0100, 1'b0, 32'h0, 254, 1'b0, 1, 1'b1, 32'hCAFE_0254), 1'b0, 1'b0, none);
    check("late_latency", 32'(last_ready_cyc - req_cyc), 32'd256);
    check("late_err",     32'(last_err), 32'd0);
    check("late_rdata",   last_rdata, 32'hCAFE_0254);

    // Reset during an ACCESS wait state.
    junk();
    present(mk(32'h1000_3000, 1'b0, 32'h1111_2222, 0, 1'b0, 0, 1'b0, '0));
    set_idle_exp();
    step();
    junk();
    apb_if.PREADY = '0;
    set_exp(1'b1, NS'(5'b01000), 1'b0, 32'h1000_3000, 32'h1111_2222, 1'b0, 1'b0, 1'b0, '0);
    step();
    rc0 = ready_cnt;
    for (int k = 0; k < 4; k++) begin
      junk();
      apb_if.PREADY = '0;
      if (k == 3) rst = 1'b1;
      set_exp(1'b1, NS'(5'b01000), 1'b1, 32'h1000_3000, 32'h1111_2222, 1'b0, 1'b0, 1'b0, '0);
      step();
    end
    rst = 1'b0;
    junk();
    transfer = 1'b0;
    set_exp(1'b1, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
    step();
    check("rst_no_ready", 32'(ready_cnt - rc0), 32'd0);

    // New transfer after reset completes normally.
    run_txn(mk(32'h1000_0008, 1'b0, 32'h0, 0, 1'b0, 1, 1'b1, 32'h1234_5678), 1'b0, 1'b0, none);
    check("post_rst_rdata",   last_rdata, 32'h1234_5678);
    check("post_rst_latency", 32'(last_ready_cyc - req_cyc), 32'd2);

    // Randomized traffic.
    for (int i = 0; i < 160; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 12)      t.addr = $urandom;
      else if (r < 20) begin
        case ($urandom_range(0, 3))
          0:       t.addr = BASE - 32'd4;
          1:       t.addr = BASE + 32'(NS * 4096);
          2:       t.addr = BASE + 32'(NS * 4096) - 32'd4;
          default: t.addr = BASE;
        endcase
      end else begin
        slot   = int'($urandom_range(0, NS - 1));
        t.addr = BASE + 32'(slot * 4096) + 32'($urandom_range(0, 1023) * 4);
      end
      t.write = 1'($urandom_range(0, 1));
      t.wdata = $urandom;
      r = int'($urandom_range(0, 99));
      if (r < 70)      t.waits = int'($urandom_range(0, 3));
      else if (r < 95) t.waits = int'($urandom_range(4, 12));
      else if (r < 98) t.waits = int'($urandom_range(253, 256));
      else             t.waits = 400;
      t.chain    = 1'($urandom_range(0, 1));
      t.gap      = int'($urandom_range(0, 2));
      t.fixed_rd = 1'b0;
      t.rd_val   = '0;
      q.push_back(t);
    end
    for (int i = 0; i < q.size(); i++) begin
      run_txn(q[i], (i > 0) && q[i-1].chain, (i + 1 < q.size()),
              (i + 1 < q.size()) ? q[i+1] : none);
    end

    junk();
    transfer = 1'b0;
    set_idle_exp();
    step();
    ex.valid = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
